// File: rtl/plic_pkg.sv
// Shared types and helpers for the PLIC claim/complete path.
package plic_pkg;

  typedef enum logic {IDLE, INSVC} claim_state_t;

  localparam int BCNT_BITS = 4;

  function automatic int id_bits(input int sources);
    return $clog2(sources + 1);
  endfunction

endpackage

// File: rtl/plic_claim_fsm.sv
// One target's claim/complete FSM with held ID, blank counter
// and registered read/error/irq outputs.
module plic_claim_fsm
  import plic_pkg::*;
#(
  parameter int SOURCES_BITS = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ireq,
  input  logic [SOURCES_BITS-1:0] id,
  input  logic                    rd_claim,
  input  logic                    wr_complete,
  input  logic [SOURCES_BITS-1:0] wr_id,
  output logic                    claim,
  output logic                    complete,
  output logic [SOURCES_BITS-1:0] rd_id,
  output logic                    rd_valid,
  output logic                    irq,
  output logic                    insvc,
  output logic                    err
);

  claim_state_t                state;
  claim_state_t                state_nx;
  logic [SOURCES_BITS-1:0]     hid;
  logic [BCNT_BITS-1:0]        bcnt;
  logic                        claim_ok;
  logic                        cmpl_ok;
  logic                        bcnt_zero;

  assign bcnt_zero = (bcnt == '0);

  // Strobes are gated by reset so the core never sees one mid-reset.
  assign claim_ok = !rst && rd_claim && (state == IDLE)
                    && ireq && (id != '0) && bcnt_zero;
  assign cmpl_ok  = !rst && wr_complete && (state == INSVC)
                    && (wr_id == hid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (claim_ok) state_nx = INSVC;
      INSVC:   if (cmpl_ok)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    claim    = claim_ok;
    complete = cmpl_ok;
    insvc    = (state == INSVC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hid      <= '0;
      bcnt     <= '0;
      rd_id    <= '0;
      rd_valid <= 1'b0;
      irq      <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (claim_ok)     hid <= id;
      else if (cmpl_ok) hid <= '0;
      if (claim_ok)        bcnt <= BCNT_BITS'(BLANK_CYCLES);
      else if (!bcnt_zero) bcnt <= bcnt - BCNT_BITS'(1);
      rd_valid <= rd_claim;
      rd_id    <= claim_ok ? id : '0;
      err      <= wr_complete && !cmpl_ok;
      // Drop irq at once on an accepted claim, not one cycle later.
      irq      <= ireq && (state == IDLE) && bcnt_zero && !claim_ok;
    end
  end

endmodule

// File: rtl/plic_claim_ctrl.sv
// Per-target claim/complete controller between plic_core and the
// bus; one independent plic_claim_fsm per target.
module plic_claim_ctrl
  import plic_pkg::*;
#(
  parameter int SOURCES      = 8,
  parameter int TARGETS      = 1,
  parameter int BLANK_CYCLES = 2,
  parameter int SOURCES_BITS = id_bits(SOURCES)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [TARGETS-1:0]                   ireq_i,
  input  logic [TARGETS-1:0][SOURCES_BITS-1:0] id_i,
  output logic [TARGETS-1:0]                   claim_o,
  output logic [TARGETS-1:0]                   complete_o,
  input  logic [TARGETS-1:0]                   rd_claim_i,
  output logic [TARGETS-1:0][SOURCES_BITS-1:0] rd_id_o,
  output logic [TARGETS-1:0]                   rd_valid_o,
  input  logic [TARGETS-1:0]                   wr_complete_i,
  input  logic [TARGETS-1:0][SOURCES_BITS-1:0] wr_id_i,
  output logic [TARGETS-1:0]                   irq_o,
  output logic [TARGETS-1:0]                   insvc_o,
  output logic [TARGETS-1:0]                   err_o
);

  for (genvar t = 0; t < TARGETS; t++) begin : g_tgt
    plic_claim_fsm #(
      .SOURCES_BITS (SOURCES_BITS),
      .BLANK_CYCLES (BLANK_CYCLES)
    ) u_fsm (
      .clk         (clk),
      .rst         (rst),
      .ireq        (ireq_i[t]),
      .id          (id_i[t]),
      .rd_claim    (rd_claim_i[t]),
      .wr_complete (wr_complete_i[t]),
      .wr_id       (wr_id_i[t]),
      .claim       (claim_o[t]),
      .complete    (complete_o[t]),
      .rd_id       (rd_id_o[t]),
      .rd_valid    (rd_valid_o[t]),
      .irq         (irq_o[t]),
      .insvc       (insvc_o[t]),
      .err         (err_o[t])
    );
  end

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Directed bench for plic_claim_ctrl, two targets, blank of 2.
module tb_plic_claim_ctrl;

  localparam int T  = 2;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [T-1:0]          ireq_i;
  logic [T-1:0][IW-1:0]  id_i;
  logic [T-1:0]          claim_o;
  logic [T-1:0]          complete_o;
  logic [T-1:0]          rd_claim_i;
  logic [T-1:0][IW-1:0]  rd_id_o;
  logic [T-1:0]          rd_valid_o;
  logic [T-1:0]          wr_complete_i;
  logic [T-1:0][IW-1:0]  wr_id_i;
  logic [T-1:0]          irq_o;
  logic [T-1:0]          insvc_o;
  logic [T-1:0]          err_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  plic_claim_ctrl #(
    .SOURCES      (8),
    .TARGETS      (T),
    .BLANK_CYCLES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ireq_i        (ireq_i),
    .id_i          (id_i),
    .claim_o       (claim_o),
    .complete_o    (complete_o),
    .rd_claim_i    (rd_claim_i),
    .rd_id_o       (rd_id_o),
    .rd_valid_o    (rd_valid_o),
    .wr_complete_i (wr_complete_i),
    .wr_id_i       (wr_id_i),
    .irq_o         (irq_o),
    .insvc_o       (insvc_o),
    .err_o         (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    ireq_i        = 2'b11;
    id_i          = '0;
    id_i[0]       = 4'd5;
    id_i[1]       = 4'd5;
    rd_claim_i    = 2'b11;
    wr_complete_i = 2'b00;
    wr_id_i       = '0;
    repeat (3) tick();
    chk("rst_claim", 32'(claim_o), 32'h0);
    chk("rst_rdv", 32'(rd_valid_o), 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    chk("rst_insvc", 32'(insvc_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_rdid", 32'(rd_id_o), 32'h0);
    rd_claim_i = 2'b00;
    ireq_i     = 2'b00;
    rst        = 1'b0;
    repeat (6) tick();

    // claim accept on target 0
    ireq_i = 2'b01;
    tick();
    chk("irq_lat", 32'(irq_o), 32'h1);
    rd_claim_i = 2'b01;
    #1;
    chk("t1_claim", 32'(claim_o), 32'h1);
    tick();
    rd_claim_i = 2'b00;
    chk("t1_rdv", 32'(rd_valid_o), 32'h1);
    chk("t1_rdid", 32'(rd_id_o[0]), 32'h5);
    chk("t1_insvc", 32'(insvc_o), 32'h1);
    chk("t1_irq", 32'(irq_o), 32'h0);
    tick();
    chk("t1_rdv_once", 32'(rd_valid_o), 32'h0);
    chk("t1_claim_once", 32'(claim_o), 32'h0);

    // second claim while in service
    rd_claim_i = 2'b01;
    #1;
    chk("t4b_claim", 32'(claim_o), 32'h0);
    tick();
    rd_claim_i = 2'b00;
    chk("t4b_rdv", 32'(rd_valid_o), 32'h1);
    chk("t4b_rdid", 32'(rd_id_o[0]), 32'h0);

    // wrong-ID complete
    wr_complete_i = 2'b01;
    wr_id_i[0]    = 4'd3;
    #1;
    chk("t3_cmpl", 32'(complete_o), 32'h0);
    tick();
    wr_complete_i = 2'b00;
    chk("t3_err", 32'(err_o), 32'h1);
    chk("t3_insvc", 32'(insvc_o), 32'h1);
    tick();
    chk("t3_err_once", 32'(err_o), 32'h0);

    // correct complete
    wr_complete_i = 2'b01;
    wr_id_i[0]    = 4'd5;
    #1;
    chk("t2_cmpl", 32'(complete_o), 32'h1);
    tick();
    wr_complete_i = 2'b00;
    chk("t2_insvc", 32'(insvc_o), 32'h0);
    chk("t2_err", 32'(err_o), 32'h0);
    chk("t2_irq_low", 32'(irq_o), 32'h0);
    tick();
    chk("t2_irq_back", 32'(irq_o), 32'h1);

    // claim then immediate complete: irq held by blank counter
    rd_claim_i = 2'b01;
    #1;
    chk("bl_claim", 32'(claim_o), 32'h1);
    tick();
    rd_claim_i    = 2'b00;
    wr_complete_i = 2'b01;
    wr_id_i[0]    = 4'd5;
    #1;
    chk("bl_cmpl", 32'(complete_o), 32'h1);
    tick();
    wr_complete_i = 2'b00;
    chk("bl_insvc", 32'(insvc_o), 32'h0);
    chk("bl_irq_a", 32'(irq_o), 32'h0);
    rd_claim_i = 2'b01;
    #1;
    chk("bl_claim_rej", 32'(claim_o), 32'h0);
    tick();
    rd_claim_i = 2'b00;
    chk("bl_rdid", 32'(rd_id_o[0]), 32'h0);
    chk("bl_rdv", 32'(rd_valid_o), 32'h1);
    chk("bl_irq_b", 32'(irq_o), 32'h0);
    tick();
    chk("bl_irq_c", 32'(irq_o), 32'h1);

    // empty claim
    ireq_i = 2'b00;
    tick();
    rd_claim_i = 2'b01;
    #1;
    chk("t4_claim", 32'(claim_o), 32'h0);
    tick();
    rd_claim_i = 2'b00;
    chk("t4_rdv", 32'(rd_valid_o), 32'h1);
    chk("t4_rdid", 32'(rd_id_o[0]), 32'h0);
    chk("t4_insvc", 32'(insvc_o), 32'h0);

    // target 0 in service with 4, target 1 in service with 2
    ireq_i  = 2'b11;
    id_i[0] = 4'd4;
    id_i[1] = 4'd2;
    rd_claim_i = 2'b11;
    #1;
    chk("t5_claim_both", 32'(claim_o), 32'h3);
    tick();
    rd_claim_i = 2'b00;
    chk("t5_rdid0", 32'(rd_id_o[0]), 32'h4);
    chk("t5_rdid1", 32'(rd_id_o[1]), 32'h2);
    repeat (3) tick();

    // simultaneous claim + complete on target 1
    id_i[1]       = 4'd7;
    rd_claim_i    = 2'b10;
    wr_complete_i = 2'b10;
    wr_id_i[1]    = 4'd2;
    #1;
    chk("t5_cmpl", 32'(complete_o), 32'h2);
    chk("t5_claim", 32'(claim_o), 32'h0);
    tick();
    rd_claim_i    = 2'b00;
    wr_complete_i = 2'b00;
    chk("t5_rdv", 32'(rd_valid_o), 32'h2);
    chk("t5_rdid_zero", 32'(rd_id_o[1]), 32'h0);
    chk("t5_insvc", 32'(insvc_o), 32'h1);
    chk("t5_err", 32'(err_o), 32'h0);
    tick();
    tick();
    rd_claim_i = 2'b10;
    #1;
    chk("t5_claim_late", 32'(claim_o), 32'h2);
    tick();
    rd_claim_i = 2'b00;
    chk("t5_rdid7", 32'(rd_id_o[1]), 32'h7);
    chk("t5_t0_insvc", 32'(insvc_o), 32'h3);
    chk("t5_t0_irq", 32'(irq_o), 32'h0);

    // asynchronous reset mid-cycle with target 0 holding ID 4
    rd_claim_i = 2'b11;
    #3;
    rst = 1'b1;
    #1;
    chk("t6_insvc", 32'(insvc_o), 32'h0);
    chk("t6_rdv", 32'(rd_valid_o), 32'h0);
    chk("t6_irq", 32'(irq_o), 32'h0);
    chk("t6_err", 32'(err_o), 32'h0);
    chk("t6_claim", 32'(claim_o), 32'h0);
    chk("t6_rdid", 32'(rd_id_o), 32'h0);
    rd_claim_i = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    chk("t6_post_insvc", 32'(insvc_o), 32'h0);
    wr_complete_i = 2'b01;
    wr_id_i[0]    = 4'd4;
    #1;
    chk("t6_cmpl", 32'(complete_o), 32'h0);
    tick();
    wr_complete_i = 2'b00;
    chk("t6_post_err", 32'(err_o), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
